micro_sequencer: RTL and testbench

- Program-issuing front end for the 8-bit bus microcontroller. It drives the micro's instruction word and data input each cycle, and captures its data output.
- Holds a 16-entry instruction store that is loaded while the sequencer is not running. On start, it runs the store from address 0 with a program counter.
- Intercepts sequencer-control opcodes (inst[7:6]=11). Supplies operands through a valid/ready input handshake and returns results as a one-cycle output strobe.

---
 rtl/micro_sequencer_pkg.sv | 32 +++
 rtl/micro_sequencer_if.sv | 35 +++
 rtl/micro_sequencer_prog_store.sv | 29 ++
 rtl/micro_sequencer.sv | 86 ++++++++
 tb/tb_micro_sequencer.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/micro_sequencer_pkg.sv
// Shared opcode fields, state encoding and instruction-class decode
// for the micro sequencer front end.
package micro_sequencer_pkg;

  localparam int DEPTH = 16;

  localparam logic [1:0] CTRL_PFX = 2'b11;
  localparam logic [1:0] SUB_HALT = 2'b00;
  localparam logic [1:0] SUB_JMP  = 2'b01;

  localparam logic [7:0] IDLE_INST = 8'hC7;
  localparam logic [7:0] HALT_INST = 8'hC0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALTED
  } state_t;

  function automatic logic is_ctrl(input logic [7:0] w);
    return w[7:6] == CTRL_PFX;
  endfunction

  function automatic logic needs_in(input logic [7:0] w);
    return !is_ctrl(w) && (w[2:0] == 3'b000);
  endfunction

  function automatic logic needs_out(input logic [7:0] w);
    return (w[7:6] == 2'b00) && (w[5:3] == 3'b000);
  endfunction

endpackage

// File: rtl/micro_sequencer_if.sv
// Host and micro-side signals of the sequencer: program load,
// operand/result handshake, status and the micro instruction bus.
interface micro_sequencer_if;

  logic       start;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       busy;
  logic       done;
  logic [3:0] pc;
  logic [7:0] m_inst;
  logic [7:0] m_din;
  logic [7:0] m_dout;

  modport slave (
    input  start, prog_we, prog_addr, prog_data,
    input  in_valid, in_data, m_dout,
    output in_ready, out_valid, out_data,
    output busy, done, pc, m_inst, m_din
  );

  modport master (
    output start, prog_we, prog_addr, prog_data,
    output in_valid, in_data, m_dout,
    input  in_ready, out_valid, out_data,
    input  busy, done, pc, m_inst, m_din
  );

endinterface

// File: rtl/micro_sequencer_prog_store.sv
// 16x8 instruction store: synchronous write, combinational read,
// every entry resets to HALT.
module seq_prog_store
  import micro_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [3:0] waddr,
  input  logic [7:0] wdata,
  input  logic [3:0] raddr,
  output logic [7:0] rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= HALT_INST;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/micro_sequencer.sv
// Program-issuing front end: fetches from the store at pc, intercepts
// control words, feeds operands to the micro and captures its results.
module micro_sequencer
  import micro_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  micro_sequencer_if.slave bus
);

  state_t     state;
  logic [3:0] pc_q;
  logic [7:0] inst_q;
  logic [7:0] din_q;
  logic [7:0] dout_q;
  logic       ov_q;
  logic [7:0] w;
  logic       store_we;

  assign store_we = bus.prog_we && (state != S_RUN);

  seq_prog_store u_store (
    .clk   (clk),
    .rst   (rst),
    .we    (store_we),
    .waddr (bus.prog_addr),
    .wdata (bus.prog_data),
    .raddr (pc_q),
    .rdata (w)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      pc_q   <= 4'd0;
      inst_q <= IDLE_INST;
      din_q  <= 8'h00;
      dout_q <= 8'h00;
      ov_q   <= 1'b0;
    end else begin
      // capture tracks the word the micro is executing now
      ov_q <= needs_out(inst_q);
      if (needs_out(inst_q)) begin
        dout_q <= bus.m_dout;
      end
      unique case (state)
        S_IDLE, S_HALTED: begin
          inst_q <= IDLE_INST;
          if (bus.start) begin
            state <= S_RUN;
            pc_q  <= 4'd0;
          end
        end
        S_RUN: begin
          if (is_ctrl(w)) begin
            inst_q <= IDLE_INST;
            unique case (1'b1)
              (w[5:4] == SUB_HALT): state <= S_HALTED;
              (w[5:4] == SUB_JMP):  pc_q  <= w[3:0];
              default:              pc_q  <= pc_q + 4'd1;
            endcase
          end else if (needs_in(w) && !bus.in_valid) begin
            inst_q <= IDLE_INST;
          end else begin
            inst_q <= w;
            pc_q   <= pc_q + 4'd1;
            if (needs_in(w)) begin
              din_q <= bus.in_data;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == S_RUN) && needs_in(w);
  assign bus.out_valid = ov_q;
  assign bus.out_data  = dout_q;
  assign bus.busy      = (state == S_RUN);
  assign bus.done      = (state == S_HALTED);
  assign bus.pc        = pc_q;
  assign bus.m_inst    = inst_q;
  assign bus.m_din     = din_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer with a small behavioural model
// of the 8-bit micro driving m_dout.
module tb_micro_sequencer;

  logic clk;
  logic rst;
  int   vectors;
  int   errors;

  micro_sequencer_if bus_if ();

  micro_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // micro model: w[5:3] selects LD (0 = data_out), w[2:0] selects OE (0 = data_in)
  logic [7:0] r [8];
  logic [7:0] src;

  always_comb begin
    src = (bus_if.m_inst[2:0] == 3'd0) ? bus_if.m_din
                                       : r[bus_if.m_inst[2:0]];
    bus_if.m_dout = (bus_if.m_inst[7:3] == 5'd0) ? src : 8'h00;
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) r[i] <= 8'h00;
    end else if (bus_if.m_inst[7:6] != 2'b11
                 && bus_if.m_inst[5:3] != 3'd0) begin
      r[bus_if.m_inst[5:3]] <= src;
    end
  end

  task automatic do_reset();
    bus_if.start     = 1'b0;
    bus_if.prog_we   = 1'b0;
    bus_if.prog_addr = 4'd0;
    bus_if.prog_data = 8'h00;
    bus_if.in_valid  = 1'b0;
    bus_if.in_data   = 8'h00;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load(input logic [3:0] a, input logic [7:0] d);
    bus_if.prog_we   = 1'b1;
    bus_if.prog_addr = a;
    bus_if.prog_data = d;
    @(negedge clk);
    bus_if.prog_we   = 1'b0;
  endtask

  task automatic pulse_start();
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] got;
    do_reset();
    got = {bus_if.busy, bus_if.done, bus_if.pc, bus_if.m_inst,
           bus_if.m_din, bus_if.out_data, bus_if.out_valid,
           bus_if.in_ready};
    vectors++;
    if (got !== {1'b0, 1'b0, 4'd0, 8'hC7, 8'h00, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got %h exp %h", got,
               {1'b0, 1'b0, 4'd0, 8'hC7, 8'h00, 8'h00, 1'b0, 1'b0});
    end
    pulse_start();
    vectors++;
    if ({bus_if.busy, bus_if.pc, bus_if.in_ready, bus_if.m_inst}
        !== {1'b1, 4'd0, 1'b0, 8'hC7}) begin
      errors++;
      $display("FAIL allhalt_run: busy=%b pc=%0d rdy=%b inst=%h exp 1 0 0 c7",
               bus_if.busy, bus_if.pc, bus_if.in_ready, bus_if.m_inst);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vectors++;
      if ({bus_if.done, bus_if.busy, bus_if.m_inst, bus_if.out_valid,
           bus_if.in_ready} !== {1'b1, 1'b0, 8'hC7, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL allhalt_done%0d: done=%b busy=%b inst=%h ov=%b rdy=%b exp 1 0 c7 0 0",
                 i, bus_if.done, bus_if.busy, bus_if.m_inst,
                 bus_if.out_valid, bus_if.in_ready);
      end
    end
  endtask

  task automatic test_program(input logic [7:0] d);
    do_reset();
    load(4'd0, 8'h10);
    load(4'd1, 8'h02);
    load(4'd2, 8'hC0);
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = d;
    pulse_start();
    vectors++;
    if ({bus_if.busy, bus_if.pc, bus_if.in_ready, bus_if.m_inst}
        !== {1'b1, 4'd0, 1'b1, 8'hC7}) begin
      errors++;
      $display("FAIL prog_fetch: busy=%b pc=%0d rdy=%b inst=%h exp 1 0 1 c7",
               bus_if.busy, bus_if.pc, bus_if.in_ready, bus_if.m_inst);
    end
    @(negedge clk);
    vectors++;
    if ({bus_if.pc, bus_if.m_inst, bus_if.m_din, bus_if.in_ready,
         bus_if.out_valid} !== {4'd1, 8'h10, d, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL prog_issue10: pc=%0d inst=%h din=%h rdy=%b ov=%b exp 1 10 %h 0 0",
               bus_if.pc, bus_if.m_inst, bus_if.m_din, bus_if.in_ready,
               bus_if.out_valid, d);
    end
    @(negedge clk);
    vectors++;
    if ({bus_if.pc, bus_if.m_inst, bus_if.out_valid}
        !== {4'd2, 8'h02, 1'b0}) begin
      errors++;
      $display("FAIL prog_issue02: pc=%0d inst=%h ov=%b exp 2 02 0",
               bus_if.pc, bus_if.m_inst, bus_if.out_valid);
    end
    @(negedge clk);
    vectors++;
    if ({bus_if.done, bus_if.busy, bus_if.pc, bus_if.m_inst,
         bus_if.out_valid, bus_if.out_data}
        !== {1'b1, 1'b0, 4'd2, 8'hC7, 1'b1, d}) begin
      errors++;
      $display("FAIL prog_capture: done=%b busy=%b pc=%0d inst=%h ov=%b od=%h exp 1 0 2 c7 1 %h",
               bus_if.done, bus_if.busy, bus_if.pc, bus_if.m_inst,
               bus_if.out_valid, bus_if.out_data, d);
    end
    @(negedge clk);
    vectors++;
    if ({bus_if.out_valid, bus_if.out_data, bus_if.m_inst}
        !== {1'b0, d, 8'hC7}) begin
      errors++;
      $display("FAIL prog_strobe_end: ov=%b od=%h inst=%h exp 0 %h c7",
               bus_if.out_valid, bus_if.out_data, bus_if.m_inst, d);
    end
    bus_if.in_valid = 1'b0;
  endtask

  task automatic test_stall();
    do_reset();
    load(4'd0, 8'h10);
    load(4'd1, 8'h02);
    load(4'd2, 8'hC0);
    bus_if.in_valid = 1'b0;
    bus_if.in_data  = 8'h05;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ({bus_if.pc, bus_if.in_ready, bus_if.m_inst, bus_if.busy}
          !== {4'd0, 1'b1, 8'hC7, 1'b1}) begin
        errors++;
        $display("FAIL stall%0d: pc=%0d rdy=%b inst=%h busy=%b exp 0 1 c7 1",
                 i, bus_if.pc, bus_if.in_ready, bus_if.m_inst, bus_if.busy);
      end
      if (i < 3) @(negedge clk);
    end
    bus_if.in_valid = 1'b1;
    @(negedge clk);
    vectors++;
    if ({bus_if.pc, bus_if.m_inst, bus_if.m_din, bus_if.in_ready}
        !== {4'd1, 8'h10, 8'h05, 1'b0}) begin
      errors++;
      $display("FAIL stall_release: pc=%0d inst=%h din=%h rdy=%b exp 1 10 05 0",
               bus_if.pc, bus_if.m_inst, bus_if.m_din, bus_if.in_ready);
    end
    bus_if.in_data = 8'h77;
    @(negedge clk);
    vectors++;
    if ({bus_if.pc, bus_if.m_inst, bus_if.m_din}
        !== {4'd2, 8'h02, 8'h05}) begin
      errors++;
      $display("FAIL stall_once: pc=%0d inst=%h din=%h exp 2 02 05",
               bus_if.pc, bus_if.m_inst, bus_if.m_din);
    end
    @(negedge clk);
    vectors++;
    if ({bus_if.done, bus_if.out_valid, bus_if.out_data, bus_if.m_din}
        !== {1'b1, 1'b1, 8'h05, 8'h05}) begin
      errors++;
      $display("FAIL stall_result: done=%b ov=%b od=%h din=%h exp 1 1 05 05",
               bus_if.done, bus_if.out_valid, bus_if.out_data, bus_if.m_din);
    end
    bus_if.in_valid = 1'b0;
  endtask

  task automatic test_jump();
    do_reset();
    load(4'd0, 8'hD3);
    load(4'd3, 8'h60);
    load(4'd4, 8'hE0);
    bus_if.in_valid  = 1'b1;
    bus_if.in_data   = 8'h33;
    bus_if.prog_we   = 1'b1;
    bus_if.prog_addr = 4'd4;
    bus_if.prog_data = 8'hC0;
    pulse_start();
    bus_if.prog_we = 1'b0;
    vectors++;
    if ({bus_if.pc, bus_if.m_inst, bus_if.busy} !== {4'd0, 8'hC7, 1'b1}) begin
      errors++;
      $display("FAIL jmp_pc0: pc=%0d inst=%h busy=%b exp 0 c7 1",
               bus_if.pc, bus_if.m_inst, bus_if.busy);
    end
    @(negedge clk);
    vectors++;
    if ({bus_if.pc, bus_if.m_inst} !== {4'd3, 8'hC7}) begin
      errors++;
      $display("FAIL jmp_target: pc=%0d inst=%h exp 3 c7",
               bus_if.pc, bus_if.m_inst);
    end
    @(negedge clk);
    vectors++;
    if ({bus_if.pc, bus_if.m_inst, bus_if.m_din}
        !== {4'd4, 8'h60, 8'h33}) begin
      errors++;
      $display("FAIL jmp_issue60: pc=%0d inst=%h din=%h exp 4 60 33",
               bus_if.pc, bus_if.m_inst, bus_if.m_din);
    end
    @(negedge clk);
    vectors++;
    if ({bus_if.pc, bus_if.m_inst, bus_if.done, bus_if.busy}
        !== {4'd4, 8'hC7, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL jmp_halt: pc=%0d inst=%h done=%b busy=%b exp 4 c7 1 0",
               bus_if.pc, bus_if.m_inst, bus_if.done, bus_if.busy);
    end
    bus_if.in_valid = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 16; i++) load(4'(i), 8'hE0);
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      vectors++;
      if ({bus_if.pc, bus_if.busy, bus_if.m_inst}
          !== {4'(i), 1'b1, 8'hC7}) begin
        errors++;
        $display("FAIL wrap_pc%0d: pc=%0d busy=%b inst=%h exp %0d 1 c7",
                 i, bus_if.pc, bus_if.busy, bus_if.m_inst, i);
      end
      bus_if.prog_we   = (i == 1);
      bus_if.prog_addr = 4'd5;
      bus_if.prog_data = 8'hC0;
      bus_if.start     = (i == 8);
      @(negedge clk);
    end
    bus_if.prog_we = 1'b0;
    bus_if.start   = 1'b0;
    vectors++;
    if ({bus_if.pc, bus_if.busy, bus_if.done} !== {4'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL wrap_zero: pc=%0d busy=%b done=%b exp 0 1 0",
               bus_if.pc, bus_if.busy, bus_if.done);
    end
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      vectors++;
      if ({bus_if.pc, bus_if.busy} !== {4'(i), 1'b1}) begin
        errors++;
        $display("FAIL wrap_pass2_%0d: pc=%0d busy=%b exp %0d 1",
                 i, bus_if.pc, bus_if.busy, i);
      end
    end
  endtask

  task automatic test_rst_mid();
    logic [31:0] got;
    do_reset();
    load(4'd0, 8'h10);
    load(4'd1, 8'h02);
    load(4'd2, 8'hC0);
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = 8'h5A;
    pulse_start();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus_if.in_valid = 1'b0;
    got = {bus_if.busy, bus_if.done, bus_if.pc, bus_if.m_inst,
           bus_if.m_din, bus_if.out_data, bus_if.out_valid,
           bus_if.in_ready};
    vectors++;
    if (got !== {1'b0, 1'b0, 4'd0, 8'hC7, 8'h00, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rst_mid_state: got %h exp %h", got,
               {1'b0, 1'b0, 4'd0, 8'hC7, 8'h00, 8'h00, 1'b0, 1'b0});
    end
    pulse_start();
    vectors++;
    if ({bus_if.busy, bus_if.pc, bus_if.in_ready, bus_if.out_valid}
        !== {1'b1, 4'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rst_mid_restart: busy=%b pc=%0d rdy=%b ov=%b exp 1 0 0 0",
               bus_if.busy, bus_if.pc, bus_if.in_ready, bus_if.out_valid);
    end
    @(negedge clk);
    vectors++;
    if ({bus_if.done, bus_if.busy, bus_if.pc, bus_if.m_inst, bus_if.out_valid}
        !== {1'b1, 1'b0, 4'd0, 8'hC7, 1'b0}) begin
      errors++;
      $display("FAIL rst_mid_halt: done=%b busy=%b pc=%0d inst=%h ov=%b exp 1 0 0 c7 0",
               bus_if.done, bus_if.busy, bus_if.pc, bus_if.m_inst,
               bus_if.out_valid);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: sim time %0t exceeded bound", $time);
    $fatal(1, "timeout");
  end

  initial begin
    vectors = 0;
    errors  = 0;
    rst     = 1'b1;
    test_reset();
    test_program(8'h05);
    test_stall();
    test_jump();
    test_wrap();
    test_rst_mid();
    test_program(8'h2A);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
